cim_ctrl: RTL
=============

Name: cim_ctrl

Overview:
Sequences one CIM crossbar tile after the upstream input-feeding stage has written its row buffer. Runs bit-serial compute over all input bit slices and steers the shift-add accumulator. Then streams column results out to the downstream function stage under backpressure. Sits between the input func stage and the output func stage. Provides the cim_busy handshake the input stage waits on.

Parameters:
xbar_size, 256, crossbar columns; number of readout addresses
datatype_size, 8, input bit width = number of bit-serial compute slices (>=2)
compute_latency, 4, cycles from o_cim_exec to valid column currents at the ADC (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_start  in  1  upstream load finished; sampled only in IDLE
i_abort  in  1  synchronous abort of current operation
i_next_busy  in  1  downstream func stage cannot accept readout
o_cim_busy  out  1  tile occupied; upstream must not start a new load
o_cim_exec  out  1  one-cycle pulse: drive bit slice o_bit_sel onto wordlines
o_bit_sel  out  $clog2(datatype_size)  current input bit slice, LSB first
o_acc_en  out  1  accumulator captures ADC output
o_acc_clr  out  1  accumulator loads instead of adds (first slice)
o_acc_sub  out  1  accumulator subtracts shifted value (MSB slice, two's complement)
o_rd_addr  out  $clog2(xbar_size)  readout column address
o_rd_valid  out  1  o_rd_addr valid this cycle
o_done  out  1  one-cycle pulse at end of operation

Behaviour:
- Reset (async): state IDLE, all counters 0, every output 0.
- States: IDLE, COMPUTE, READOUT, DONE (enum in package).
- IDLE: o_cim_busy=0. i_start=1 -> COMPUTE next cycle. bit_cnt=0, lat_cnt=0.
- COMPUTE: o_cim_busy=1. Each slice takes 1+compute_latency cycles.
  - Cycle 0 of slice: o_cim_exec=1, o_bit_sel=bit_cnt.
  - Cycles 1..compute_latency: lat_cnt counts. On the last one, o_acc_en=1.
  - o_acc_clr=1 with acc_en when bit_cnt=0. o_acc_sub=1 with acc_en when bit_cnt=datatype_size-1.
  - o_bit_sel is held through the whole slice.
  - After the MSB slice's acc_en -> READOUT. Total: datatype_size*(1+compute_latency) cycles (40 at defaults).
- READOUT: o_cim_busy=1.
  - i_next_busy=0: o_rd_valid=1 and the address advances 0..xbar_size-1, one per cycle.
  - i_next_busy=1: o_rd_valid=0 and the address holds (the held address is re-presented when the stall ends).
  - After address xbar_size-1 is issued with valid -> DONE. The address wraps to 0; there is no overrun.
- DONE: one cycle. o_done=1, o_cim_busy=1 -> IDLE. i_start in DONE is ignored.
- i_start outside IDLE: ignored. Upstream is responsible for holding off while o_cim_busy=1.
- i_abort=1 in any non-IDLE state: next cycle IDLE, counters 0, no o_done. i_abort has priority over all other events. In IDLE it has no effect, and it beats a simultaneous i_start.
- rst mid-operation: immediate IDLE; no pulses emitted afterwards.
- All outputs are registered-state decodes; no combinational path from inputs to outputs except o_rd_valid from i_next_busy.
- Counters are sized with $clog2 of their limit and compare against limit-1; no integer-width counters.

Optional Feature:
CIM_CTRL_PERF_EN.
- Defined: adds outputs o_perf_cycles (32 bit, counts non-IDLE cycles, saturating) and o_perf_stalls (32 bit, counts READOUT cycles with i_next_busy=1, saturating).
  - Both clear on rst.
  - Both also clear on the i_start cycle that leaves IDLE.
  - Values hold after DONE until the next start.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package cim_pkg: ctrl_state_t enum (IDLE, COMPUTE, READOUT, DONE) and a shared clog2-min-1 width helper constant function.
- One sub-module, cim_rd_seq: the readout address generator.
  - Inputs: start, stall, abort.
  - Outputs: addr, valid, last.
  - cim_ctrl instantiates it for READOUT.

Test Plan:
- Defaults, i_start pulse, i_next_busy=0:
  - o_cim_busy rises the next cycle.
  - 8 exec pulses at 5-cycle spacing with bit_sel 0..7.
  - acc_en at exec+4; clr on slice 0, sub on slice 7.
  - 256 consecutive rd_valid with addr 0..255, then o_done 297 cycles after start (1+40+256), busy low the cycle after.
- i_next_busy high for 10 cycles at addr 100: rd_valid=0, addr held at 100; resumes at 100; o_done delayed by exactly 10 cycles.
- i_abort during COMPUTE slice 3: IDLE next cycle, all outputs 0, no o_done; a following i_start restarts at bit_sel 0 with clr.
- Async rst asserted mid-READOUT between clock edges: outputs 0 before the next edge; i_start during busy is ignored throughout.
- i_abort and i_start together in IDLE: the start is not taken.
- With CIM_CTRL_PERF_EN, 10-cycle stall run: o_perf_cycles=307, o_perf_stalls=10 after DONE.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM tile controller.
package cim_pkg;

    // Controller phases for one tile operation.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        READOUT = 2'd2,
        DONE    = 2'd3
    } ctrl_state_t;

    // Counter width for a limit, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cim_rd_seq.sv
// Readout address generator: walks column addresses 0..DEPTH-1 once per arm.
//
// Handshake: o_valid = "o_addr is offered this cycle"; i_stall is the
// inverse of ready. A beat transfers exactly when o_valid=1 (which already
// implies no stall); a stalled address is held and re-offered unchanged.
import cim_pkg::*;

module cim_rd_seq #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_stall,
    input  logic          i_abort,
    output logic [AW-1:0] o_addr,
    output logic          o_valid,
    output logic          o_last
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    logic          r_active;
    logic [AW-1:0] r_addr;
    logic          w_beat;

    assign w_beat  = r_active & ~i_stall;
    assign o_valid = w_beat;
    assign o_addr  = r_addr;
    assign o_last  = w_beat && (r_addr == ADDR_LAST);

    // Arm on start, advance one address per accepted beat, wrap to 0 after the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_addr   <= '0;
        end else if (i_abort) begin
            r_active <= 1'b0;
            r_addr   <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_addr   <= '0;
        end else if (w_beat) begin
            if (r_addr == ADDR_LAST) begin
                r_active <= 1'b0;
                r_addr   <= '0;
            end else begin
                r_addr <= r_addr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/cim_ctrl.sv
// CIM crossbar tile controller: bit-serial compute over all input slices,
// accumulator steering, then column readout under downstream backpressure.
// Optional build macro CIM_CTRL_PERF_EN adds cycle/stall performance counters.
import cim_pkg::*;

module cim_ctrl #(
    parameter int XBAR_SIZE       = 256,
    parameter int DATATYPE_SIZE   = 8,
    parameter int COMPUTE_LATENCY = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_start,
    input  logic                                i_abort,
    input  logic                                i_next_busy,
    output logic                                o_cim_busy,
    output logic                                o_cim_exec,
    output logic [clog2_min1(DATATYPE_SIZE)-1:0] o_bit_sel,
    output logic                                o_acc_en,
    output logic                                o_acc_clr,
    output logic                                o_acc_sub,
    output logic [clog2_min1(XBAR_SIZE)-1:0]     o_rd_addr,
    output logic                                o_rd_valid,
    output logic                                o_done
`ifdef CIM_CTRL_PERF_EN
    ,
    output logic [31:0]                         o_perf_cycles,
    output logic [31:0]                         o_perf_stalls
`endif
);

    localparam int BW = clog2_min1(DATATYPE_SIZE);
    localparam int AW = clog2_min1(XBAR_SIZE);
    localparam int LW = clog2_min1(COMPUTE_LATENCY + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATATYPE_SIZE - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(COMPUTE_LATENCY);

    ctrl_state_t r_state;
    logic [BW-1:0] r_bit_cnt;
    logic [LW-1:0] r_lat_cnt;

    logic w_slice_end;
    logic w_msb_end;
    logic w_rd_start;
    logic w_rd_last;

    // A slice ends on its final latency cycle; the MSB slice ends the compute phase.
    assign w_slice_end = (r_state == COMPUTE) && (r_lat_cnt == LAT_LAST);
    assign w_msb_end   = w_slice_end && (r_bit_cnt == BIT_LAST);
    assign w_rd_start  = w_msb_end && !i_abort;

    cim_rd_seq #(
        .DEPTH (XBAR_SIZE),
        .AW    (AW)
    ) u_rd_seq (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_rd_start),
        .i_stall (i_next_busy),
        .i_abort (i_abort),
        .o_addr  (o_rd_addr),
        .o_valid (o_rd_valid),
        .o_last  (w_rd_last)
    );

    // Phase sequencing; abort wins over every other event and returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_lat_cnt <= '0;
        end else if (i_abort) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_lat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    r_lat_cnt <= '0;
                    if (i_start) begin
                        r_state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_lat_cnt <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= READOUT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LW'(1);
                    end
                end
                READOUT: begin
                    if (w_rd_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_cim_busy = (r_state != IDLE);
    assign o_cim_exec = (r_state == COMPUTE) && (r_lat_cnt == '0);
    assign o_bit_sel  = r_bit_cnt;
    assign o_acc_en   = w_slice_end;
    assign o_acc_clr  = w_slice_end && (r_bit_cnt == '0);
    assign o_acc_sub  = w_msb_end;
    assign o_done     = (r_state == DONE);

`ifdef CIM_CTRL_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    // Saturating busy-cycle and readout-stall counters, cleared when an operation starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (r_state == IDLE) begin
            if (i_start && !i_abort) begin
                r_perf_cycles <= '0;
                r_perf_stalls <= '0;
            end
        end else begin
            if (r_perf_cycles != '1) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if ((r_state == READOUT) && i_next_busy && (r_perf_stalls != '1)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign o_perf_cycles = r_perf_cycles;
    assign o_perf_stalls = r_perf_stalls;
`endif

endmodule
